// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register.
// Optional subtract mode (i_sub port) is enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
`ifdef CHUNKED_ADDER_SUB_EN
  input  logic             i_sub,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
      $error("chunked_serial_adder: CHUNK must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_b_load;
  logic               w_cin_load;
  logic [WIDTH-1:0]   w_a_shift;
  logic [WIDTH-1:0]   w_b_shift;
  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK:0]     w_sum;
  logic               w_c_msb;
  logic [WIDTH-1:0]   w_s_next;

`ifdef CHUNKED_ADDER_SUB_EN
  // Subtraction is A + ~B + 1; the forced carry replaces Cin.
  assign w_b_load   = i_sub ? ~i_b : i_b;
  assign w_cin_load = i_sub | i_cin;
`else
  assign w_b_load   = i_b;
  assign w_cin_load = i_cin;
`endif

  assign w_accept  = i_start && (r_state != ST_RUN);
  assign w_last    = (r_cnt == LAST_CNT);

  assign w_a_shift = r_a >> (32'(r_cnt) * CHUNK);
  assign w_b_shift = r_b >> (32'(r_cnt) * CHUNK);
  assign w_a_chunk = w_a_shift[CHUNK-1:0];
  assign w_b_chunk = w_b_shift[CHUNK-1:0];
  assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the chunk MSB recovered from the MSB sum bit; on the last chunk this is the carry into bit WIDTH-1.
  assign w_c_msb   = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_sum[CHUNK-1];

  always_comb begin
    w_s_next = r_s;
    for (int k = 0; k < NCHUNK; k++) begin
      if (int'(r_cnt) == k) begin
        w_s_next[k*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        o_busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_state_next = i_start ? ST_RUN : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= w_b_load;
      r_carry <= w_cin_load;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_s     <= w_s_next;
      r_carry <= w_sum[CHUNK];
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_cout <= w_sum[CHUNK];
        r_ovf  <= w_c_msb ^ w_sum[CHUNK];
      end
    end
  end

  assign o_s    = r_s;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Self-checking bench: an 8-bit/4-bit-chunk instance and a 32-bit single-chunk instance against an arithmetic model.
module tb_chunked_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  s8;

  logic        start32, cin32, sub32;
  logic [31:0] a32, b32;
  logic        busy32, done32, cout32, ovf32;
  logic [31:0] s32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chunked_serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8), .i_cin(cin8),
`ifdef CHUNKED_ADDER_SUB_EN
    .i_sub(sub8),
`endif
    .o_busy(busy8), .o_done(done8), .o_s(s8), .o_cout(cout8), .o_ovf(ovf8)
  );

  chunked_serial_adder #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_start(start32), .i_a(a32), .i_b(b32), .i_cin(cin32),
`ifdef CHUNKED_ADDER_SUB_EN
    .i_sub(sub32),
`endif
    .o_busy(busy32), .o_done(done32), .o_s(s32), .o_cout(cout32), .o_ovf(ovf32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands, signed overflow from operand/result signs.
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    logic [8:0] full;
    logic [7:0] s;
    logic       cout, ovf;
    if (sub) begin
      s    = a - b;
      cout = (a >= b);
      ovf  = (a[7] != b[7]) && (s[7] != a[7]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      s    = full[7:0];
      cout = full[8];
      ovf  = (a[7] == b[7]) && (s[7] != a[7]);
    end
    return {ovf, cout, s};
  endfunction

  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [32:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    ovf  = (a[31] == b[31]) && (full[31] != a[31]);
    return {ovf, full};
  endfunction

  // Called at a negedge; returns at a negedge one cycle after the done cycle.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub, input bit poke);
    logic [9:0] exp;
    int         cyc;
    exp    = model8(a, b, cin, sub);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
    @(negedge clk);
    start8 = poke;
    a8 = ~a; b8 = a; cin8 = ~cin;
    check("op8_busy", {31'd0, busy8}, 32'd1);
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    $display("op8 a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d ovf=%0d cycles=%0d", a, b, cin, sub, s8, cout8, ovf8, cyc);
    check("op8_latency", cyc, 32'd3);
    check("op8_busy_at_done", {31'd0, busy8}, 32'd0);
    check("op8_s", {24'd0, s8}, {24'd0, exp[7:0]});
    check("op8_cout", {31'd0, cout8}, {31'd0, exp[8]});
    check("op8_ovf", {31'd0, ovf8}, {31'd0, exp[9]});
    @(negedge clk);
    check("op8_done_pulse", {31'd0, done8}, 32'd0);
    check("op8_s_held", {24'd0, s8}, {24'd0, exp[7:0]});
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [33:0] exp;
    int          cyc;
    exp     = model32(a, b, cin);
    start32 = 1'b1; a32 = a; b32 = b; cin32 = cin; sub32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    cyc = 1;
    while (!done32 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("op32 a=%h b=%h cin=%0d -> s=%h cout=%0d ovf=%0d cycles=%0d", a, b, cin, s32, cout32, ovf32, cyc);
    check("op32_latency", cyc, 32'd2);
    check("op32_s", s32, exp[31:0]);
    check("op32_cout", {31'd0, cout32}, {31'd0, exp[32]});
    check("op32_ovf", {31'd0, ovf32}, {31'd0, exp[33]});
    @(negedge clk);
    check("op32_done_pulse", {31'd0, done32}, 32'd0);
  endtask

  initial begin
    int         seen;
    int         cyc;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    start32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_s8", {24'd0, s8}, 32'd0);
    check("rst_cout8", {31'd0, cout8}, 32'd0);
    check("rst_ovf8", {31'd0, ovf8}, 32'd0);
    check("rst_busy32", {31'd0, busy32}, 32'd0);
    check("rst_s32", s32, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
    op8(8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
    op8(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held high; operand changes while busy must be ignored
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0;
    @(negedge clk);
    a8 = 8'hEE; b8 = 8'hEE; cin8 = 1'b1;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    $display("b2b first s=%h cycles=%0d", s8, cyc);
    check("b2b_first_latency", cyc, 32'd3);
    check("b2b_first_s", {24'd0, s8}, 32'h30);
    a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
    @(negedge clk);
    a8 = 8'h99; b8 = 8'h99;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start8 = 1'b0;
    $display("b2b second s=%h cycles=%0d", s8, cyc);
    check("b2b_second_gap", cyc, 32'd3);
    check("b2b_second_s", {24'd0, s8}, 32'h07);
    @(negedge clk);

    // Reset mid-RUN after the first chunk
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("abort s=%h busy=%0d done=%0d", s8, busy8, done8);
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_s", {24'd0, s8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done8) seen++;
    end
    check("abort_no_done", seen, 32'd0);
    op8(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);

    // Single-chunk 32-bit instance
    op32(32'hFFFF_FFFF, 32'h0, 1'b1);
    op32(32'h7FFF_FFFF, 32'h1, 1'b0);

`ifdef CHUNKED_ADDER_SUB_EN
    op8(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
`endif

    // Randomised operations
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
`ifdef CHUNKED_ADDER_SUB_EN
      op8(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      op8(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
`endif
    end
    for (int i = 0; i < 10; i++) begin
      op32($urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
